// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: tick strobe, column walk, row debounce,
// one key code at a time to the bus side over a valid/ack handshake.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   rows_in      keypad rows (active low, asynchronous)
//   cols_out     column drive (active low, one bit low)
//   key_code     {row,col} of the last reported key
//   key_valid    new key_code pending until key_ack
//   key_ack      one-cycle consume pulse from the bus side
//   key_down     a debounced key is currently held
//   overrun      sticky: report arrived while key_valid was still set
//   irq          key interrupt, built only with KEYPAD_IRQ_EN
//
// Optional feature macro: KEYPAD_IRQ_EN
module keypad_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows_in,
    output logic [3:0] cols_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun,
    output logic       irq
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
    localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        REPORT,
        RELEASE
    } state_t;

    state_t          state;
    logic [TW-1:0]   tcnt;
    logic            tick;
    logic [3:0]      rows_m;
    logic [3:0]      rows_s;
    logic [1:0]      col_idx;
    logic [DW-1:0]   deb_cnt;
    logic [3:0]      pattern;
    logic [1:0]      row;
    logic [1:0]      low_row;
    logic            ack_hit;

    assign tick     = (tcnt == T_LAST);
    assign ack_hit  = key_ack && key_valid;
    assign cols_out = ~(4'b0001 << col_idx);

    always_comb begin
        low_row = 2'd3;
        if (!rows_s[0])
            low_row = 2'd0;
        else if (!rows_s[1])
            low_row = 2'd1;
        else if (!rows_s[2])
            low_row = 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    // Idle value of the synchroniser is "no key" so reset never looks
    // like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= rows_in;
            rows_s <= rows_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
            pattern   <= 4'hF;
            row       <= 2'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ack_hit) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
            // REPORT comes after the ack clear so a same-cycle report wins.
            unique case (state)
                SCAN: if (tick) begin
                    if (rows_s != 4'hF) begin
                        row     <= low_row;
                        pattern <= rows_s;
                        deb_cnt <= '0;
                        state   <= DEBOUNCE;
                    end else begin
                        col_idx <= col_idx + 2'd1;
                    end
                end
                DEBOUNCE: if (tick) begin
                    if (rows_s == pattern) begin
                        if (deb_cnt == D_LAST)
                            state <= REPORT;
                        else
                            deb_cnt <= deb_cnt + 1'b1;
                    end else begin
                        col_idx <= col_idx + 2'd1;
                        state   <= SCAN;
                    end
                end
                REPORT: begin
                    key_code  <= {row, col_idx};
                    key_valid <= 1'b1;
                    key_down  <= 1'b1;
                    if (key_valid && !key_ack)
                        overrun <= 1'b1;
                    deb_cnt   <= '0;
                    state     <= RELEASE;
                end
                RELEASE: if (tick) begin
                    if (rows_s == 4'hF) begin
                        if (deb_cnt == D_LAST) begin
                            key_down <= 1'b0;
                            col_idx  <= col_idx + 2'd1;
                            state    <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

`ifdef KEYPAD_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else if (state == REPORT)
            irq <= 1'b1;
        else if (ack_hit)
            irq <= 1'b0;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (CLK_DIV=4, DEBOUNCE_CNT=3).
// Directed table vectors plus hand sequences for multi-cycle cases.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] rows_in;
    logic [3:0] cols_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;
    logic       irq;

    int n_cmp;
    int n_err;

`ifdef KEYPAD_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    keypad_scan_ctrl #(
        .CLK_DIV(4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rows_in(rows_in),
        .cols_out(cols_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ack(key_ack),
        .key_down(key_down),
        .overrun(overrun),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rows;
        logic       ack;
        int         wait_n;
        logic [3:0] cols;
        logic       valid;
        logic       down;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name,
                         input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_table();
        for (int i = 0; i < 5; i++) begin
            rows_in = tbl[i].rows;
            key_ack = tbl[i].ack;
            step(tbl[i].wait_n);
            check($sformatf("tbl%0d_cols", i), {4'h0, cols_out},
                  {4'h0, tbl[i].cols});
            check($sformatf("tbl%0d_valid", i), {7'h0, key_valid},
                  {7'h0, tbl[i].valid});
            check($sformatf("tbl%0d_down", i), {7'h0, key_down},
                  {7'h0, tbl[i].down});
            check($sformatf("tbl%0d_irq", i), {7'h0, irq},
                  {7'h0, IRQ_ON & tbl[i].valid});
        end
        key_ack = 1'b0;
    endtask

    // Aligns to the negedge right after the tick edge that selects c.
    task automatic wait_col(input logic [3:0] c);
        int n;
        n = 0;
        while (cols_out == c && n < 40) begin
            step(1);
            n++;
        end
        while (cols_out != c && n < 40) begin
            step(1);
            n++;
        end
        check("wait_col", {4'h0, cols_out}, {4'h0, c});
    endtask

    task automatic wait_release();
        int n;
        n = 0;
        while (key_down && n < 40) begin
            step(1);
            n++;
        end
        check("wait_release", {7'h0, key_down}, 8'h0);
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cols"}, {4'h0, cols_out}, 8'h0E);
        check({tag, "_code"}, {4'h0, key_code}, 8'h00);
        check({tag, "_valid"}, {7'h0, key_valid}, 8'h00);
        check({tag, "_down"}, {7'h0, key_down}, 8'h00);
        check({tag, "_ovr"}, {7'h0, overrun}, 8'h00);
        check({tag, "_irq"}, {7'h0, irq}, 8'h00);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        tbl[0] = '{4'hF, 1'b0, 1, 4'b1110, 1'b0, 1'b0};
        tbl[1] = '{4'hF, 1'b0, 4, 4'b1101, 1'b0, 1'b0};
        tbl[2] = '{4'hF, 1'b1, 4, 4'b1011, 1'b0, 1'b0};
        tbl[3] = '{4'hF, 1'b0, 4, 4'b0111, 1'b0, 1'b0};
        tbl[4] = '{4'hF, 1'b0, 4, 4'b1110, 1'b0, 1'b0};

        rst_n   = 1'b0;
        rows_in = 4'hF;
        key_ack = 1'b0;
        step(2);
        check_reset_vals("rst");
        rst_n = 1'b1;
        run_table();

        // Key 9 (row2, col1): exact latency and frozen column.
        wait_col(4'b1101);
        rows_in = 4'b1011;
        step(16);
        check("lat_valid_lo", {7'h0, key_valid}, 8'h00);
        step(1);
        check("k9_valid", {7'h0, key_valid}, 8'h01);
        check("k9_code", {4'h0, key_code}, 8'd9);
        check("k9_down", {7'h0, key_down}, 8'h01);
        check("k9_cols", {4'h0, cols_out}, 8'h0D);
        check("k9_irq", {7'h0, irq}, {7'h0, IRQ_ON});
        pulse_ack();
        check("k9_ack_valid", {7'h0, key_valid}, 8'h00);
        check("k9_ack_irq", {7'h0, irq}, 8'h00);

        // Held for 20 ticks: no repeat, column frozen.
        step(80);
        check("hold_valid", {7'h0, key_valid}, 8'h00);
        check("hold_down", {7'h0, key_down}, 8'h01);
        check("hold_cols", {4'h0, cols_out}, 8'h0D);
        rows_in = 4'hF;
        step(10);
        check("rel_early", {7'h0, key_down}, 8'h01);
        n = 0;
        while (key_down && n < 4) begin
            step(1);
            n++;
        end
        check("rel_down", {7'h0, key_down}, 8'h00);
        check("rel_cols", {4'h0, cols_out}, 8'h0B);

        // One-tick glitch on col3: held, then abandoned with 3->0 wrap.
        wait_col(4'b0111);
        rows_in = 4'b1110;
        step(4);
        check("gl_hold", {4'h0, cols_out}, 8'h07);
        rows_in = 4'hF;
        step(4);
        check("gl_cols", {4'h0, cols_out}, 8'h0E);
        check("gl_valid", {7'h0, key_valid}, 8'h00);
        check("gl_down", {7'h0, key_down}, 8'h00);

        // Key 9 left unacked, then key 3 with ack in the REPORT cycle.
        wait_col(4'b1101);
        rows_in = 4'b1011;
        n = 0;
        while (!key_valid && n < 40) begin
            step(1);
            n++;
        end
        check("d9_code", {4'h0, key_code}, 8'd9);
        rows_in = 4'hF;
        wait_release();
        wait_col(4'b0111);
        rows_in = 4'b1110;
        step(16);
        pulse_ack();
        check("race_valid", {7'h0, key_valid}, 8'h01);
        check("race_code", {4'h0, key_code}, 8'd3);
        check("race_ovr", {7'h0, overrun}, 8'h00);
        rows_in = 4'hF;
        wait_release();

        // Key 9 on top of unacked key 3: overrun.
        wait_col(4'b1101);
        rows_in = 4'b1011;
        n = 0;
        while (key_code != 4'd9 && n < 40) begin
            step(1);
            n++;
        end
        check("ovr_code", {4'h0, key_code}, 8'd9);
        check("ovr_valid", {7'h0, key_valid}, 8'h01);
        check("ovr_flag", {7'h0, overrun}, 8'h01);
        pulse_ack();
        check("ovr_ack_valid", {7'h0, key_valid}, 8'h00);
        check("ovr_ack_flag", {7'h0, overrun}, 8'h00);
        rows_in = 4'hF;
        wait_release();

        // Reset mid-debounce on key 6.
        wait_col(4'b1011);
        rows_in = 4'b1101;
        step(6);
        check("mid_cols", {4'h0, cols_out}, 8'h0B);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid");
        rows_in = 4'hF;
        step(1);
        rst_n = 1'b1;
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
